// File: rtl/pagerank_update_engine.sv
// Iterative PageRank update stage: accumulates streamed contributions, applies damping,
// measures the L1 delta against the previous ranks and drives the iteration loop.
module pagerank_update_engine #(
   parameter int unsigned NODES    = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned FRAC_W   = 16,
   parameter int unsigned MAX_ITER = 500
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           stream_valid,
   input  logic                           stream_start,
   input  logic                           stream_done,
   input  logic [NODES-1:0][DATA_W-1:0]   stream_data,
   input  logic [DATA_W-1:0]              damping_factor,
   input  logic [DATA_W-1:0]              threshold,
   output logic [NODES-1:0][DATA_W-1:0]   pagerank_final,
   output logic [31:0]                    iteration_number,
   output logic [DATA_W-1:0]              delta,
   output logic                           next_iteration,
   output logic                           pagerank_complete,
   output logic                           converged,
   output logic                           busy,
   output logic                           protocol_err
);

   localparam int unsigned LG    = $clog2(NODES);
   localparam int unsigned SUM_W = DATA_W + LG;

   localparam logic [DATA_W:0]   One      = (DATA_W + 1)'(1) << FRAC_W;
   localparam logic [DATA_W-1:0] InitRank = DATA_W'(One >> LG);
   localparam logic [LG-1:0]     IdxLast  = LG'(NODES - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StWait   = 3'd1;
   localparam logic [2:0] StAccum  = 3'd2;
   localparam logic [2:0] StDamp   = 3'd3;
   localparam logic [2:0] StDelta  = 3'd4;
   localparam logic [2:0] StDecide = 3'd5;
   localparam logic [2:0] StDone   = 3'd6;

   logic [2:0]                    state_q, state_d;
   logic [DATA_W-1:0]             d_q, d_d;
   logic [DATA_W-1:0]             thr_q, thr_d;
   logic [NODES-1:0][DATA_W-1:0]  acc_q, acc_d;
   logic [NODES-1:0][DATA_W-1:0]  prev_q, prev_d;
   logic [NODES-1:0][DATA_W-1:0]  pr_q, pr_d;
   logic [SUM_W-1:0]              sum_q, sum_d;
   logic [LG-1:0]                 idx_q, idx_d;
   logic [31:0]                   iter_q, iter_d;
   logic [DATA_W-1:0]             delta_q, delta_d;
   logic                          conv_q, conv_d;
   logic                          perr_q, perr_d;

   logic [DATA_W:0]               base;
   logic [DATA_W-1:0]             cur_pr, cur_prev, abs_diff;

   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DATA_W] ? '1 : s[DATA_W-1:0];
   endfunction

   // base + (d*acc >> FRAC_W), saturated to DATA_W
   function automatic logic [DATA_W-1:0] damp_node(input logic [DATA_W-1:0] d,
                                                   input logic [DATA_W:0]   b,
                                                   input logic [DATA_W-1:0] a);
      logic [2*DATA_W-1:0] prod;
      logic [2*DATA_W:0]   tot;
      prod = {{DATA_W{1'b0}}, d} * {{DATA_W{1'b0}}, a};
      tot  = {1'b0, prod >> FRAC_W} + {{DATA_W{1'b0}}, b};
      return (|tot[2*DATA_W:DATA_W]) ? '1 : tot[DATA_W-1:0];
   endfunction

   always_comb begin
      // An out-of-range damping factor clamps the teleport term to zero rather than wrapping.
      base     = ({1'b0, d_q} > One) ? '0 : ((One - {1'b0, d_q}) >> LG);
      cur_pr   = pr_q[idx_q];
      cur_prev = prev_q[idx_q];
      abs_diff = (cur_pr >= cur_prev) ? (cur_pr - cur_prev) : (cur_prev - cur_pr);
   end

   always_comb begin
      state_d        = state_q;
      d_d            = d_q;
      thr_d          = thr_q;
      acc_d          = acc_q;
      prev_d         = prev_q;
      pr_d           = pr_q;
      sum_d          = sum_q;
      idx_d          = idx_q;
      iter_d         = iter_q;
      delta_d        = delta_q;
      conv_d         = conv_q;
      perr_d         = perr_q;
      next_iteration = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               d_d     = damping_factor;
               thr_d   = threshold;
               prev_d  = {NODES{InitRank}};
               iter_d  = '0;
               perr_d  = 1'b0;
               conv_d  = 1'b0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (stream_valid && stream_start) begin
               acc_d   = stream_data;
               state_d = stream_done ? StDamp : StAccum;
            end
         end
         StAccum: begin
            if (stream_valid) begin
               if (stream_start) begin
                  acc_d  = stream_data;
                  perr_d = 1'b1;
               end else begin
                  for (int i = 0; i < NODES; i++) begin
                     acc_d[i] = sat_add(acc_q[i], stream_data[i]);
                  end
               end
               if (stream_done) state_d = StDamp;
            end
         end
         StDamp: begin
            for (int i = 0; i < NODES; i++) begin
               pr_d[i] = damp_node(d_q, base, acc_q[i]);
            end
            sum_d   = '0;
            idx_d   = '0;
            state_d = StDelta;
         end
         StDelta: begin
            sum_d = sum_q + {{LG{1'b0}}, abs_diff};
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxLast) state_d = StDecide;
         end
         StDecide: begin
            iter_d  = iter_q + 32'd1;
            delta_d = (|sum_q[SUM_W-1:DATA_W]) ? '1 : sum_q[DATA_W-1:0];
            if (sum_q < {{LG{1'b0}}, thr_q}) begin
               conv_d  = 1'b1;
               state_d = StDone;
            end else if (({1'b0, iter_q} + 33'd1) >= 33'(MAX_ITER)) begin
               conv_d  = 1'b0;
               state_d = StDone;
            end else begin
               next_iteration = 1'b1;
               prev_d         = pr_q;
               state_d        = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         d_q     <= '0;
         thr_q   <= '0;
         acc_q   <= '0;
         prev_q  <= '0;
         pr_q    <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         iter_q  <= '0;
         delta_q <= '0;
         conv_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         thr_q   <= thr_d;
         acc_q   <= acc_d;
         prev_q  <= prev_d;
         pr_q    <= pr_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         iter_q  <= iter_d;
         delta_q <= delta_d;
         conv_q  <= conv_d;
         perr_q  <= perr_d;
      end
   end

   assign pagerank_final    = pr_q;
   assign iteration_number  = iter_q;
   assign delta             = delta_q;
   assign converged         = conv_q;
   assign protocol_err      = perr_q;
   assign pagerank_complete = (state_q == StDone);
   assign busy              = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_pagerank_update_engine.sv
// Bench for pagerank_update_engine: directed table, corner-case sequences and randomized runs
// against an arithmetic reference model (NODES=4, FRAC_W=16, MAX_ITER=3).
module tb_pagerank_update_engine;

   localparam int NODES = 4;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   stream_valid, stream_start, stream_done;
   logic [3:0][31:0]       stream_data;
   logic [31:0]            damping_factor, threshold;
   logic [3:0][31:0]       pagerank_final;
   logic [31:0]            iteration_number, delta;
   logic                   next_iteration, pagerank_complete, converged, busy, protocol_err;

   int checks = 0;
   int errors = 0;

   logic [3:0][31:0] beat_mem [4];
   int               nbeats;

   typedef struct {
      logic [31:0] d;
      logic [31:0] thr;
      int          nbeats;
      logic [31:0] beat0;
      logic [31:0] beat1;
      logic [31:0] exp_pr;
      logic [31:0] exp_delta1;
      logic [31:0] exp_delta;
      logic        exp_conv;
      int          exp_iter;
      int          exp_pulses;
   } vec_t;

   vec_t tbl [6];

   pagerank_update_engine #(
      .NODES    (4),
      .DATA_W   (32),
      .FRAC_W   (16),
      .MAX_ITER (3)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .stream_valid      (stream_valid),
      .stream_start      (stream_start),
      .stream_done       (stream_done),
      .stream_data       (stream_data),
      .damping_factor    (damping_factor),
      .threshold         (threshold),
      .pagerank_final    (pagerank_final),
      .iteration_number  (iteration_number),
      .delta             (delta),
      .next_iteration    (next_iteration),
      .pagerank_complete (pagerank_complete),
      .converged         (converged),
      .busy              (busy),
      .protocol_err      (protocol_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [31:0] d, input logic [31:0] thr);
      damping_factor = d;
      threshold      = thr;
      start          = 1'b1;
      tick();
      start          = 1'b0;
   endtask

   task automatic drive_beat(input logic s, input logic dn, input logic [3:0][31:0] data);
      stream_valid = 1'b1;
      stream_start = s;
      stream_done  = dn;
      stream_data  = data;
      tick();
      stream_valid = 1'b0;
      stream_start = 1'b0;
      stream_done  = 1'b0;
   endtask

   task automatic idle_noise();
      stream_valid = 1'b0;
      stream_start = 1'($urandom);
      stream_done  = 1'($urandom);
      for (int n = 0; n < NODES; n++) stream_data[n] = $urandom;
      tick();
      stream_start = 1'b0;
      stream_done  = 1'b0;
   endtask

   task automatic send_stream(input bit gaps);
      logic [3:0][31:0] junk;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         for (int n = 0; n < NODES; n++) junk[n] = $urandom;
         drive_beat(1'b0, 1'($urandom), junk);  // no stream_start: dropped while waiting
      end
      for (int k = 0; k < nbeats; k++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) idle_noise();
         end
         drive_beat(k == 0, k == nbeats - 1, beat_mem[k]);
      end
   endtask

   // 1 = next_iteration seen, 2 = complete seen, 0 = neither within budget
   task automatic wait_outcome(output int outcome, output int cyc);
      outcome = 0;
      cyc     = 0;
      for (int c = 0; c < 40; c++) begin
         if (next_iteration === 1'b1) begin
            outcome = 1;
            break;
         end
         if (pagerank_complete === 1'b1) begin
            outcome = 2;
            break;
         end
         tick();
         cyc++;
      end
   endtask

   function automatic longint unsigned m_sat(input longint unsigned v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   function automatic longint unsigned m_pr(input longint unsigned d, input longint unsigned acc);
      longint unsigned base;
      base = (65536 - d) / 4;
      return m_sat(base + ((d * acc) / 65536));
   endfunction

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int oc, cyc, pulses;
      bit first;
      vec_t v;
      logic [3:0][31:0] bd;
      longint unsigned md, mthr, miter, msum, exp_oc;
      longint unsigned macc [4];
      longint unsigned mprev [4];
      longint unsigned mpr [4];

      tbl[0] = '{32'd55705, 32'd10, 1, 32'd16384, 32'd0, 32'd16383, 32'd4, 32'd4, 1'b1, 1, 0};
      tbl[1] = '{32'd55705, 32'd10, 2, 32'd8192, 32'd8192, 32'd16383, 32'd4, 32'd4, 1'b1, 1, 0};
      tbl[2] = '{32'd55705, 32'd10, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3650685336,
                 32'hFFFF_FFFF, 32'd0, 1'b1, 2, 1};
      tbl[3] = '{32'd0, 32'd10, 1, 32'd1000, 32'd0, 32'd16384, 32'd0, 32'd0, 1'b1, 1, 0};
      tbl[4] = '{32'd65536, 32'd1, 1, 32'd20000, 32'd0, 32'd20000, 32'd14464, 32'd0, 1'b1, 2, 1};
      tbl[5] = '{32'd55705, 32'd0, 1, 32'd16384, 32'd0, 32'd16383, 32'd4, 32'd0, 1'b0, 3, 2};

      reset = 1'b1;
      start = 1'b0;
      stream_valid = 1'b0;
      stream_start = 1'b0;
      stream_done = 1'b0;
      stream_data = '0;
      damping_factor = '0;
      threshold = '0;
      tick();
      tick();
      check("rst_pr", pagerank_final, 0);
      check("rst_iter", iteration_number, 0);
      check("rst_delta", delta, 0);
      check("rst_flags", {next_iteration, pagerank_complete, converged, busy, protocol_err}, 0);
      reset = 1'b0;
      tick();

      // Directed table
      for (int e = 0; e < 6; e++) begin
         v = tbl[e];
         do_start(v.d, v.thr);
         check($sformatf("t%0d_busy", e), busy, 1);
         pulses = 0;
         first  = 1'b1;
         for (int it = 0; it < 5; it++) begin
            for (int n = 0; n < NODES; n++) begin
               beat_mem[0][n] = v.beat0;
               beat_mem[1][n] = v.beat1;
            end
            nbeats = v.nbeats;
            send_stream(1'b0);
            wait_outcome(oc, cyc);
            if (oc == 1) begin
               check($sformatf("t%0d_lat_pulse", e), cyc, NODES + 1);
               pulses++;
               tick();
               check($sformatf("t%0d_pulse_width", e), next_iteration, 0);
               if (first) check($sformatf("t%0d_delta1", e), delta, v.exp_delta1);
               first = 1'b0;
            end else begin
               check($sformatf("t%0d_no_timeout", e), oc, 2);
               check($sformatf("t%0d_lat_done", e), cyc, NODES + 2);
               if (first) check($sformatf("t%0d_delta1", e), delta, v.exp_delta1);
               break;
            end
         end
         for (int n = 0; n < NODES; n++)
            check($sformatf("t%0d_pr[%0d]", e, n), pagerank_final[n], v.exp_pr);
         check($sformatf("t%0d_delta", e), delta, v.exp_delta);
         check($sformatf("t%0d_conv", e), converged, v.exp_conv);
         check($sformatf("t%0d_iter", e), iteration_number, v.exp_iter);
         check($sformatf("t%0d_pulses", e), pulses, v.exp_pulses);
         check($sformatf("t%0d_done_busy", e), {pagerank_complete, busy, protocol_err}, 3'b100);
      end

      // Restarted stream: sticky protocol_err, accumulator restarts at 100
      do_start(32'd55705, 32'd10);
      bd = {4{32'd5000}};
      drive_beat(1'b1, 1'b0, bd);
      bd = {4{32'd100}};
      drive_beat(1'b1, 1'b0, bd);
      check("perr_set", protocol_err, 1);
      bd = '0;
      drive_beat(1'b0, 1'b1, bd);
      wait_outcome(oc, cyc);
      check("perr_pulse", oc, 1);
      tick();
      check("perr_pr0", pagerank_final[0], 32'd2541);
      check("perr_pr3", pagerank_final[3], 32'd2541);
      check("perr_delta", delta, 32'd55372);
      nbeats = 1;
      beat_mem[0] = {4{32'd100}};
      send_stream(1'b0);
      wait_outcome(oc, cyc);
      check("perr_done", oc, 2);
      check("perr_conv", converged, 1);
      check("perr_iter", iteration_number, 2);
      check("perr_sticky", protocol_err, 1);
      do_start(32'd55705, 32'd10);
      check("perr_cleared", protocol_err, 0);

      // Asynchronous reset while in DELTA
      bd = {4{32'd16384}};
      drive_beat(1'b1, 1'b1, bd);
      tick();
      check("mid_pr_before", pagerank_final[2], 32'd16383);
      check("mid_busy_before", busy, 1);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_pr", pagerank_final, 0);
      check("mid_rst_flags", {next_iteration, pagerank_complete, converged, busy, protocol_err}, 0);
      check("mid_rst_iter", iteration_number, 0);
      check("mid_rst_delta", delta, 0);
      #1;
      reset = 1'b0;
      tick();

      // start while busy must be ignored
      do_start(32'd55705, 32'd10);
      bd = {4{32'd16384}};
      drive_beat(1'b1, 1'b0, bd);
      do_start(32'd0, 32'd0);
      bd = '0;
      drive_beat(1'b0, 1'b1, bd);
      wait_outcome(oc, cyc);
      check("ign_done", oc, 2);
      check("ign_lat", cyc, NODES + 2);
      check("ign_pr1", pagerank_final[1], 32'd16383);
      check("ign_conv", converged, 1);
      check("ign_iter", iteration_number, 1);

      // Randomized runs against the reference model
      for (int r = 0; r < 30; r++) begin
         md   = $urandom_range(0, 65536);
         mthr = ($urandom_range(0, 3) == 0) ? longint'($urandom) : $urandom_range(0, 100000);
         do_start(32'(md), 32'(mthr));
         for (int n = 0; n < NODES; n++) mprev[n] = 16384;
         miter = 0;
         for (int it = 0; it < 5; it++) begin
            nbeats = $urandom_range(1, 3);
            for (int k = 0; k < nbeats; k++)
               for (int n = 0; n < NODES; n++)
                  beat_mem[k][n] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 70000);
            msum = 0;
            for (int n = 0; n < NODES; n++) begin
               macc[n] = beat_mem[0][n];
               for (int k = 1; k < nbeats; k++) macc[n] = m_sat(macc[n] + beat_mem[k][n]);
               mpr[n] = m_pr(md, macc[n]);
               msum += (mpr[n] >= mprev[n]) ? mpr[n] - mprev[n] : mprev[n] - mpr[n];
            end
            miter++;
            exp_oc = (msum < mthr || miter >= 3) ? 2 : 1;
            send_stream(1'b1);
            wait_outcome(oc, cyc);
            check($sformatf("r%0d_i%0d_outcome", r, it), oc, exp_oc);
            if (oc == 1) tick();
            for (int n = 0; n < NODES; n++)
               check($sformatf("r%0d_i%0d_pr[%0d]", r, it, n), pagerank_final[n], mpr[n]);
            check($sformatf("r%0d_i%0d_delta", r, it), delta, m_sat(msum));
            check($sformatf("r%0d_i%0d_iter", r, it), iteration_number, miter);
            if (oc != exp_oc) break;
            if (exp_oc == 2) begin
               check($sformatf("r%0d_conv", r), converged, msum < mthr);
               check($sformatf("r%0d_complete", r), {pagerank_complete, busy}, 2'b10);
               break;
            end
            for (int n = 0; n < NODES; n++) mprev[n] = mpr[n];
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pagerank_update_engine.md
Name: pagerank_update_engine

Overview:
- Parametrised successor to the single-shot PageRank compute stage.
- Accumulates multi-beat per-node contribution vectors from the DMP phase and applies damping in unsigned fixed point.
- Computes the L1 delta against the previous iteration, then either requests another iteration or declares completion (converged or iteration cap).
- Sits between the DMP scatter/gather stream and the host/result interface. Owns the iteration loop and previous-rank storage.

Parameters:
- NODES, 32: nodes in graph partition; must be a power of two, ≥2.
- DATA_W, 32: width of each rank/contribution word, unsigned fixed point.
- FRAC_W, 16: fractional bits; ONE = 2^FRAC_W; requires FRAC_W < DATA_W.
- MAX_ITER, 500: iteration cap, ≥1.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new run; honoured only in IDLE or DONE.
- stream_valid  input  1  qualifies stream_data/stream_start/stream_done this cycle.
- stream_start  input  1  first beat of an iteration's stream (valid-qualified).
- stream_done  input  1  last beat of an iteration's stream (valid-qualified); may coincide with stream_start.
- stream_data  input  NODES x DATA_W  per-node contributions for this beat.
- damping_factor  input  DATA_W  d in fixed point, must be ≤ ONE; sampled at start.
- threshold  input  DATA_W  convergence threshold; sampled at start.
- pagerank_final  output  NODES x DATA_W  latest computed ranks.
- iteration_number  output  32  completed iterations this run.
- delta  output  DATA_W  last L1 delta, saturated.
- next_iteration  output  1  one-cycle pulse: issue another DMP pass.
- pagerank_complete  output  1  level, high in DONE.
- converged  output  1  valid in DONE: 1 = delta<threshold, 0 = cap reached.
- busy  output  1  high in every state except IDLE/DONE.
- protocol_err  output  1  sticky, set on restarted stream; cleared by start.

Behaviour:
- Reset (async): state IDLE; all outputs 0; pagerank_final 0; accumulators 0; prev ranks 0.
- start in IDLE/DONE: latch d and threshold; prev[i] = ONE>>log2(NODES); iteration_number=0; clear protocol_err, converged; go WAIT_STREAM. start in any other state is ignored.
- WAIT_STREAM: beats without stream_start are dropped. On valid&&stream_start: acc[i] = stream_data[i]. If stream_done is also set, go DAMP, else ACCUM.
- ACCUM: on valid beat, acc[i] = sat(acc[i]+stream_data[i]), saturating at 2^DATA_W-1. If stream_done, go DAMP. If stream_start arrives mid-stream: acc[i] = stream_data[i] (restart) and protocol_err = 1. No valid: hold.
- DAMP (1 cycle): base = (ONE-d)>>log2(NODES), floor. pagerank_final[i] = sat(base + ((d*acc[i])>>FRAC_W)). Product is 2*DATA_W wide; truncate toward zero.
- DELTA (NODES cycles, index 0..NODES-1, one node per cycle): sum += |pagerank_final[k]-prev[k]|. The sum is held DATA_W+log2(NODES) wide; the delta output is saturated to DATA_W.
- DECIDE (1 cycle): iteration_number += 1 (visible next cycle).
  - If sum<threshold: converged=1, go DONE.
  - Else if iteration_number+1 ≥ MAX_ITER: converged=0, go DONE.
  - Else: next_iteration=1 this cycle, prev = pagerank_final, go WAIT_STREAM.
- Latency: stream_done beat accepted at cycle T → DAMP at T+1 → DELTA T+2..T+1+NODES → DECIDE T+2+NODES.
- DONE: pagerank_complete=1 and all outputs held until start or reset. Stream input is ignored.
- Reset mid-operation: immediate return to IDLE with reset values; no next_iteration glitch.

Test Plan:
- NODES=4, FRAC_W=16, d=55705, threshold=10; start, then one beat with start+done, data 16384 each → pagerank_final all 16383, delta=4, converged=1, pagerank_complete=1, iteration_number=1, no next_iteration pulse.
- Same, threshold=0, MAX_ITER=3, identical stream each pass → next_iteration pulses exactly twice, DONE with converged=0, iteration_number=3.
- Two beats (start, then done), data 8192 then 8192 → acc 16384, pagerank_final 16383. Done asserted NODES+2 cycles after the last beat.
- Two beats of 0xFFFFFFFF → acc saturates 0xFFFFFFFF, pagerank_final = 3650685336 each.
- stream_start re-asserted mid-ACCUM with data 100 → protocol_err=1, acc restarts at 100.
- reset asserted during DELTA → all outputs 0 asynchronously, state IDLE. Afterwards, start during busy is ignored and the run completes normally.
